// File: rtl/id_pkg.sv
// Shared widths, instruction field offsets and the ID/EX payload layout
// for the decode stage.
package id_pkg;

  localparam int unsigned XLEN    = 8;
  localparam int unsigned AW      = 3;
  localparam int unsigned INSTR_W = 8;
  localparam int unsigned IMM_W   = 3;

  localparam int unsigned RS1_LSB = 0;
  localparam int unsigned RD_LSB  = AW;
  localparam int unsigned IMM_LSB = 0;

  // ID/EX payload at the default widths
  typedef struct packed {
    logic            sign_extend_reg;
    logic            write_reg;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [XLEN-1:0] imm;
  } id_ex_t;

endpackage

// File: rtl/reg_file_p.sv
// Register file with two combinational read ports, one synchronous write
// port, write-back bypass and optional hard-wired zero register.
module reg_file_p #(
  parameter int unsigned XLEN     = id_pkg::XLEN,
  parameter int unsigned AW       = id_pkg::AW,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr1_i,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  import id_pkg::*;

  localparam int unsigned NREG = 1 << AW;
  localparam logic        ZERO_EN = (ZERO_REG != 0);

  logic [XLEN-1:0] rf_q [NREG];
  logic            wr_en;

  assign wr_en = we_i && !(ZERO_EN && (waddr_i == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  // Zero register wins over the bypass; bypass wins over the stored value
  always_comb begin
    rdata1_o = rf_q[raddr1_i];
    if (ZERO_EN && (raddr1_i == '0))          rdata1_o = '0;
    else if (we_i && (waddr_i == raddr1_i))   rdata1_o = wdata_i;
  end

  always_comb begin
    rdata2_o = rf_q[raddr2_i];
    if (ZERO_EN && (raddr2_i == '0))          rdata2_o = '0;
    else if (we_i && (waddr_i == raddr2_i))   rdata2_o = wdata_i;
  end

endmodule

// File: rtl/id_stage_p.sv
// Instruction decode stage: field split, operand read with bypass,
// immediate extension and a valid/ready ID/EX register with flush.
module id_stage_p #(
  parameter int unsigned XLEN     = id_pkg::XLEN,
  parameter int unsigned INSTR_W  = id_pkg::INSTR_W,
  parameter int unsigned AW       = id_pkg::AW,
  parameter int unsigned IMM_W    = id_pkg::IMM_W,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [INSTR_W-1:0] instruction_i,
  input  logic               sign_extend_reg_i,
  input  logic               write_reg_i,
  input  logic               flush_i,
  input  logic               wb_write_reg_i,
  input  logic [AW-1:0]      wb_rd_i,
  input  logic [XLEN-1:0]    wb_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               out_sign_extend_reg_o,
  output logic               out_write_reg_o,
  output logic [AW-1:0]      out_rs1_o,
  output logic [AW-1:0]      out_rd_o,
  output logic [XLEN-1:0]    out_data1_o,
  output logic [XLEN-1:0]    out_data2_o,
  output logic [XLEN-1:0]    out_imm_o
);

  import id_pkg::*;

  // Same layout as id_pkg::id_ex_t, sized by this instance's parameters
  typedef struct packed {
    logic            sign_extend_reg;
    logic            write_reg;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [XLEN-1:0] imm;
  } payload_t;

  logic [AW-1:0]    rs1;
  logic [AW-1:0]    rd;
  logic [IMM_W-1:0] imm;
  logic [XLEN-1:0]  imm_ext;
  logic [XLEN-1:0]  rdata1;
  logic [XLEN-1:0]  rdata2;
  payload_t         dec;
  payload_t         pay_q, pay_d;
  logic             valid_q, valid_d;
  logic             capture;
  logic             consume;

  assign rs1 = instruction_i[RS1_LSB +: AW];
  assign rd  = instruction_i[AW +: AW];
  assign imm = instruction_i[IMM_LSB +: IMM_W];

  generate
    if (INSTR_W > 2 * AW) begin : g_hi_bits
      logic unused_hi;
      assign unused_hi = ^instruction_i[INSTR_W-1:2*AW];
    end
  endgenerate

  reg_file_p #(
    .XLEN     (XLEN),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (wb_write_reg_i),
    .waddr_i  (wb_rd_i),
    .wdata_i  (wb_data_i),
    .raddr1_i (rs1),
    .raddr2_i (rd),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2)
  );

  assign imm_ext = sign_extend_reg_i ? {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm}
                                     : {{(XLEN-IMM_W){1'b0}}, imm};

  always_comb begin
    dec                 = '0;
    dec.sign_extend_reg = sign_extend_reg_i;
    dec.write_reg       = write_reg_i;
    dec.rs1             = rs1;
    dec.rd              = rd;
    dec.data1           = rdata1;
    dec.data2           = rdata2;
    dec.imm             = imm_ext;
  end

  assign in_ready_o = !valid_q || out_ready_i;
  assign capture    = in_valid_i && in_ready_o;
  assign consume    = valid_q && out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pay_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pay_q   <= pay_d;
    end
  end

  // Flush beats capture; payload is left untouched on flush
  always_comb begin
    valid_d = valid_q;
    pay_d   = pay_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      pay_d   = dec;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  assign out_valid_o           = valid_q;
  assign out_sign_extend_reg_o = pay_q.sign_extend_reg;
  assign out_write_reg_o       = pay_q.write_reg;
  assign out_rs1_o             = pay_q.rs1;
  assign out_rd_o              = pay_q.rd;
  assign out_data1_o           = pay_q.data1;
  assign out_data2_o           = pay_q.data2;
  assign out_imm_o             = pay_q.imm;

endmodule

// File: tb/tb_id_stage_p.sv
// Self-checking bench for id_stage_p: directed vector table, stall/reset
// sequences and randomized traffic against a behavioural model.
module tb_id_stage_p;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] instruction;
  logic       sext;
  logic       wr;
  logic       flush;
  logic       wb_we;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;
  logic       out_valid;
  logic       out_ready;
  logic       o_sext, o_wr;
  logic [2:0] o_rs1, o_rd;
  logic [7:0] o_d1, o_d2, o_imm;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_stage_p dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .in_valid_i            (in_valid),
    .in_ready_o            (in_ready),
    .instruction_i         (instruction),
    .sign_extend_reg_i     (sext),
    .write_reg_i           (wr),
    .flush_i               (flush),
    .wb_write_reg_i        (wb_we),
    .wb_rd_i               (wb_rd),
    .wb_data_i             (wb_data),
    .out_valid_o           (out_valid),
    .out_ready_i           (out_ready),
    .out_sign_extend_reg_o (o_sext),
    .out_write_reg_o       (o_wr),
    .out_rs1_o             (o_rs1),
    .out_rd_o              (o_rd),
    .out_data1_o           (o_d1),
    .out_data2_o           (o_d2),
    .out_imm_o             (o_imm)
  );

  typedef struct {
    logic       iv;
    logic [7:0] ins;
    logic       sx;
    logic       wrr;
    logic       fl;
    logic       we;
    logic [2:0] wrd;
    logic [7:0] wd;
    logic       ordy;
    logic       e_valid;
    logic [7:0] e_d1;
    logic [7:0] e_d2;
    logic [7:0] e_imm;
  } vec_t;

  // Behavioural model: register array plus the architectural ID/EX contents
  int unsigned m_rf [8];
  logic        m_valid;
  logic        m_sext, m_wr;
  int unsigned m_rs1, m_rd, m_d1, m_d2, m_imm;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned m_read(input int unsigned a);
    if (a == 0) return 0;
    if (wb_we && int'(wb_rd) == int'(a)) return int'(wb_data);
    return m_rf[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 0;
    m_valid = 1'b0; m_sext = 1'b0; m_wr = 1'b0;
    m_rs1 = 0; m_rd = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic m_edge();
    bit          rdy, cap, con;
    int unsigned a1, a2, im;
    rdy = !m_valid || out_ready;
    cap = in_valid && rdy;
    con = m_valid && out_ready;
    a1  = instruction % 8;
    a2  = (instruction / 8) % 8;
    im  = instruction % 8;
    if (sext && im >= 4) im = im + 256 - 8;
    if (flush) m_valid = 1'b0;
    else if (cap) begin
      m_valid = 1'b1; m_sext = sext; m_wr = wr;
      m_rs1 = a1; m_rd = a2;
      m_d1 = m_read(a1); m_d2 = m_read(a2); m_imm = im;
    end else if (con) m_valid = 1'b0;
    if (wb_we && wb_rd != 3'd0) m_rf[wb_rd] = int'(wb_data);
  endtask

  task automatic cmp_outputs();
    chk("out_valid", out_valid, m_valid);
    chk("out_sext",  o_sext,    m_sext);
    chk("out_wr",    o_wr,      m_wr);
    chk("out_rs1",   o_rs1,     m_rs1);
    chk("out_rd",    o_rd,      m_rd);
    chk("out_data1", o_d1,      m_d1);
    chk("out_data2", o_d2,      m_d2);
    chk("out_imm",   o_imm,     m_imm);
  endtask

  // Called at posedge+1: drive, check in_ready, clock, check outputs
  task automatic apply(input vec_t v);
    in_valid = v.iv; instruction = v.ins; sext = v.sx; wr = v.wrr;
    flush = v.fl; wb_we = v.we; wb_rd = v.wrd; wb_data = v.wd;
    out_ready = v.ordy;
    #1;
    chk("in_ready", in_ready, !m_valid || out_ready);
    m_edge();
    @(posedge clk);
    #1;
    cmp_outputs();
  endtask

  function automatic vec_t mk(input logic iv, input logic [7:0] ins, input logic sx,
                              input logic fl, input logic we, input logic [2:0] wrd,
                              input logic [7:0] wd, input logic ordy,
                              input logic ev, input logic [7:0] ed1,
                              input logic [7:0] ed2, input logic [7:0] eim);
    vec_t v;
    v.iv = iv; v.ins = ins; v.sx = sx; v.wrr = ins[7]; v.fl = fl;
    v.we = we; v.wrd = wrd; v.wd = wd; v.ordy = ordy;
    v.e_valid = ev; v.e_d1 = ed1; v.e_d2 = ed2; v.e_imm = eim;
    return v;
  endfunction

  vec_t tbl [8];
  vec_t v;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instruction = '0; sext = 1'b0; wr = 1'b0;
    flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    cmp_outputs();

    //            iv  ins     sx  fl  we  wrd   wd     ordy ev  d1     d2     imm
    tbl[0] = mk(0, 8'h00, 0, 0, 1, 3'd3, 8'h5A, 1, 0, 8'h00, 8'h00, 8'h00);
    tbl[1] = mk(1, 8'h1B, 0, 0, 0, 3'd0, 8'h00, 1, 1, 8'h5A, 8'h5A, 8'h03);
    tbl[2] = mk(1, 8'h02, 1, 0, 1, 3'd2, 8'hC3, 1, 1, 8'hC3, 8'h00, 8'h02);
    tbl[3] = mk(1, 8'h0D, 1, 0, 0, 3'd0, 8'h00, 1, 1, 8'h00, 8'h00, 8'hFD);
    tbl[4] = mk(1, 8'h0D, 0, 0, 0, 3'd0, 8'h00, 1, 1, 8'h00, 8'h00, 8'h05);
    tbl[5] = mk(0, 8'h00, 0, 0, 1, 3'd0, 8'hFF, 1, 0, 8'h00, 8'h00, 8'h05);
    tbl[6] = mk(1, 8'h00, 0, 0, 1, 3'd0, 8'h77, 1, 1, 8'h00, 8'h00, 8'h00);
    tbl[7] = mk(1, 8'h1B, 0, 1, 0, 3'd0, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00);

    for (int i = 0; i < 8; i++) begin
      apply(tbl[i]);
      chk($sformatf("vec%0d_valid", i), out_valid, tbl[i].e_valid);
      chk($sformatf("vec%0d_data1", i), o_d1,      tbl[i].e_d1);
      chk($sformatf("vec%0d_data2", i), o_d2,      tbl[i].e_d2);
      chk($sformatf("vec%0d_imm", i),   o_imm,     tbl[i].e_imm);
    end

    // Stall: A held for 3 cycles while B waits; a write-back to A's rs1 must not leak in
    apply(mk(1, 8'h19, 0, 0, 1, 3'd1, 8'h42, 1, 0, 0, 0, 0));
    chk("stall_A_rs1", o_rs1, 1);
    chk("stall_A_data1", o_d1, 8'h42);
    for (int k = 0; k < 3; k++) begin
      apply(mk(1, 8'h14, 0, 0, 1, 3'd1, 8'h11, 0, 0, 0, 0, 0));
      chk("stall_in_ready", in_ready, 0);
      chk("stall_hold_rs1", o_rs1, 1);
      chk("stall_hold_data1", o_d1, 8'h42);
      chk("stall_hold_valid", out_valid, 1);
    end
    apply(mk(1, 8'h14, 0, 0, 0, 3'd0, 8'h00, 1, 0, 0, 0, 0));
    chk("stall_B_rs1", o_rs1, 4);
    chk("stall_B_rd", o_rd, 2);
    apply(mk(0, 8'h00, 0, 0, 0, 3'd0, 8'h00, 1, 0, 0, 0, 0));
    chk("stall_B_once", out_valid, 0);

    // Reset asserted in the middle of a stall
    apply(mk(1, 8'h1B, 0, 0, 0, 3'd0, 8'h00, 1, 0, 0, 0, 0));
    apply(mk(1, 8'h14, 0, 0, 0, 3'd0, 8'h00, 0, 0, 0, 0, 0));
    chk("pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("async_reset_valid", out_valid, 0);
    chk("async_reset_data1", o_d1, 0);
    cmp_outputs();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(mk(1, 8'h1B, 0, 0, 0, 3'd0, 8'h00, 1, 0, 0, 0, 0));
    chk("post_reset_rf3", o_d1, 0);
    chk("post_reset_valid", out_valid, 1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      v.iv   = ($urandom_range(0, 3) != 0);
      v.ins  = 8'($urandom);
      v.sx   = 1'($urandom);
      v.wrr  = 1'($urandom);
      v.fl   = ($urandom_range(0, 15) == 0);
      v.we   = 1'($urandom);
      v.wrd  = 3'($urandom);
      v.wd   = 8'($urandom);
      v.ordy = ($urandom_range(0, 2) != 0);
      in_valid = v.iv; instruction = v.ins; sext = v.sx; wr = v.wrr;
      flush = v.fl; wb_we = v.we; wb_rd = v.wrd; wb_data = v.wd;
      out_ready = v.ordy;
      #1;
      chk("rnd_in_ready", in_ready, !m_valid || out_ready);
      m_edge();
      @(posedge clk);
      #1;
      cmp_outputs();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
